// File: rtl/stat_bist_ctrl.sv
// stat_bist_ctrl
//   BIST sequencer for a combinational CUT. It drives cut_in with LFSR patterns,
//   holds each pattern for SETTLE extra cycles and then folds cut_out into a
//   MISR. At the end of the run it compares the signature with golden.
//
// Ports
//   clk, rst_n  clock (rising edge) and asynchronous active-low reset
//   start       pulse; starts a run when idle
//   abort       stops a run in progress (HOLD/CAPTURE only)
//   seed        LFSR seed, sampled when start is accepted (0 is forced to 1)
//   golden      expected signature, sampled in FINISH
//   cut_in      registered drive to the CUT inputs
//   cut_out     CUT outputs, combinational from cut_in
//   busy        high while a run is in progress
//   done        one-cycle pulse when a run completes (not on abort)
//   pass        signature==golden; valid after done, held until next start
//   signature   MISR contents, held after a run or abort
//   pat_idx     index of the pattern currently applied
module stat_bist_ctrl #(
  parameter int unsigned      IN_W      = 20,
  parameter int unsigned      OUT_W     = 24,
  parameter int unsigned      PAT_CNT   = 256,
  parameter int unsigned      SETTLE    = 1,
  parameter logic [IN_W-1:0]  LFSR_TAPS = 20'h90000,
  parameter logic [OUT_W-1:0] MISR_TAPS = 24'hE10000,
  parameter int unsigned      CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [IN_W-1:0]  seed,
  input  logic [OUT_W-1:0] golden,
  output logic [IN_W-1:0]  cut_in,
  input  logic [OUT_W-1:0] cut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [OUT_W-1:0] signature,
  output logic [CNT_W-1:0] pat_idx
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_CAPTURE,
    S_FINISH
  } state_t;

  // The hold counter runs 0..SETTLE-1; keep it at least one bit wide.
  localparam int unsigned      HOLD_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = (SETTLE > 0) ? HOLD_W'(SETTLE - 1) : '0;
  localparam logic [CNT_W-1:0]  PAT_LAST  = CNT_W'(PAT_CNT - 1);
  localparam state_t            FIRST_ST  = (SETTLE > 0) ? S_HOLD : S_CAPTURE;

  state_t            state, state_n;
  logic [HOLD_W-1:0] hold_cnt, hold_n;
  logic [IN_W-1:0]   cut_in_n;
  logic [OUT_W-1:0]  sig_n;
  logic [CNT_W-1:0]  pat_n;
  logic              busy_n, done_n, pass_n;

  logic [IN_W-1:0]   lfsr_next;
  logic [OUT_W-1:0]  misr_next;

  always_comb begin
    lfsr_next = {cut_in[IN_W-2:0], ^(cut_in & LFSR_TAPS)};
    misr_next = {signature[OUT_W-2:0], ^(signature & MISR_TAPS)} ^ cut_out;
  end

  always_comb begin
    state_n  = state;
    hold_n   = hold_cnt;
    cut_in_n = cut_in;
    sig_n    = signature;
    pat_n    = pat_idx;
    busy_n   = busy;
    done_n   = 1'b0;
    pass_n   = pass;

    unique case (state)
      S_IDLE: begin
        // abort is ignored here, so start+abort still launches a run.
        if (start) begin
          cut_in_n = (seed == '0) ? IN_W'(1) : seed;
          sig_n    = '0;
          pat_n    = '0;
          pass_n   = 1'b0;
          busy_n   = 1'b1;
          hold_n   = '0;
          state_n  = FIRST_ST;
        end
      end

      S_HOLD: begin
        if (abort) begin
          busy_n  = 1'b0;
          pass_n  = 1'b0;
          state_n = S_IDLE;
        end else if (hold_cnt == HOLD_LAST) begin
          hold_n  = '0;
          state_n = S_CAPTURE;
        end else begin
          hold_n = hold_cnt + 1'b1;
        end
      end

      S_CAPTURE: begin
        // abort wins over the capture: signature stays at its partial value.
        if (abort) begin
          busy_n  = 1'b0;
          pass_n  = 1'b0;
          state_n = S_IDLE;
        end else begin
          sig_n = misr_next;
          if (pat_idx == PAT_LAST) begin
            // busy drops and done rises together on entry to FINISH.
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = S_FINISH;
          end else begin
            cut_in_n = lfsr_next;
            pat_n    = pat_idx + 1'b1;
            hold_n   = '0;
            state_n  = FIRST_ST;
          end
        end
      end

      S_FINISH: begin
        pass_n  = (signature == golden);
        state_n = S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      hold_cnt  <= '0;
      cut_in    <= '0;
      signature <= '0;
      pat_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      state     <= state_n;
      hold_cnt  <= hold_n;
      cut_in    <= cut_in_n;
      signature <= sig_n;
      pat_idx   <= pat_n;
      busy      <= busy_n;
      done      <= done_n;
      pass      <= pass_n;
    end
  end

endmodule

// File: tb/tb_stat_bist_ctrl.sv
// tb_stat_bist_ctrl
//   Three instances of stat_bist_ctrl:
//     u1   PAT_CNT=1,   SETTLE=0  single-pattern MISR vectors from a table
//     u4   PAT_CNT=4,   SETTLE=1  pattern sequence, start-while-busy, abort, reset
//     u256 PAT_CNT=256, SETTLE=1  behavioural CUT, random seeds, stuck-at fault
//   Inputs are driven and outputs sampled on the falling clock edge.
module tb_stat_bist_ctrl;

  localparam logic [19:0] LT = 20'h90000;
  localparam logic [23:0] MT = 24'hE10000;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // u1 signals
  logic        start1 = 1'b0, abort1 = 1'b0;
  logic [19:0] seed1 = '0;
  logic [23:0] golden1 = '0, cutout1 = '0;
  logic [19:0] cutin1;
  logic        busy1, done1, pass1;
  logic [23:0] sig1;
  logic [15:0] idx1;

  // u4 signals
  logic        start4 = 1'b0, abort4 = 1'b0;
  logic [19:0] seed4 = '0;
  logic [23:0] golden4 = '0, cutout4 = '0;
  logic [19:0] cutin4;
  logic        busy4, done4, pass4;
  logic [23:0] sig4;
  logic [15:0] idx4;

  // u256 signals
  logic        start256 = 1'b0, abort256 = 1'b0, stuck = 1'b0;
  logic [19:0] seed256 = '0;
  logic [23:0] golden256 = '0, cutout256;
  logic [19:0] cutin256;
  logic        busy256, done256, pass256;
  logic [23:0] sig256;
  logic [15:0] idx256;

  stat_bist_ctrl #(.PAT_CNT(1), .SETTLE(0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .seed(seed1),
    .golden(golden1), .cut_in(cutin1), .cut_out(cutout1), .busy(busy1),
    .done(done1), .pass(pass1), .signature(sig1), .pat_idx(idx1));

  stat_bist_ctrl #(.PAT_CNT(4), .SETTLE(1)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4), .seed(seed4),
    .golden(golden4), .cut_in(cutin4), .cut_out(cutout4), .busy(busy4),
    .done(done4), .pass(pass4), .signature(sig4), .pat_idx(idx4));

  stat_bist_ctrl #(.PAT_CNT(256), .SETTLE(1)) u256 (
    .clk(clk), .rst_n(rst_n), .start(start256), .abort(abort256), .seed(seed256),
    .golden(golden256), .cut_in(cutin256), .cut_out(cutout256), .busy(busy256),
    .done(done256), .pass(pass256), .signature(sig256), .pat_idx(idx256));

  function automatic logic [19:0] lfsr_step(input logic [19:0] x);
    return {x[18:0], ^(x & LT)};
  endfunction

  function automatic logic [23:0] misr_step(input logic [23:0] s, input logic [23:0] d);
    return {s[22:0], ^(s & MT)} ^ d;
  endfunction

  // Stand-in for a Stat_128-class combinational CUT.
  function automatic logic [23:0] cut_fn(input logic [19:0] x);
    logic [43:0] m;
    m = {24'h0, x} * 44'h9E37;
    return m[23:0] ^ {x[3:0], x};
  endfunction

  assign cutout256 = cut_fn(cutin256) | (stuck ? 24'h000020 : 24'h000000);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // 4-pattern run, seed 1, cut_out 0. With poke set, start is pulsed mid-run
  // (must be ignored) and abort is raised during FINISH (must be ignored).
  task automatic run_basic(input bit poke);
    int unsigned bad, nd;
    bad = 0; nd = 0;
    @(negedge clk); seed4 = 20'h00001; cutout4 = '0; golden4 = '0; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (poke && c == 3) begin start4 = 1'b1; seed4 = 20'h55555; end
      else start4 = 1'b0;
      if (busy4 !== 1'b1 || cutin4 !== (20'h1 << (c / 2)) || idx4 !== 16'(c / 2)) bad++;
      if (done4 === 1'b1) nd++;
      @(negedge clk);
    end
    start4 = 1'b0;
    chk("basic_seq", 32'(bad), 32'd0);
    chk("basic_done", 32'(done4), 32'd1);
    chk("basic_busy_fall", 32'(busy4), 32'd0);
    chk("basic_sig", 32'(sig4), 32'd0);
    if (done4 === 1'b1) nd++;
    if (poke) abort4 = 1'b1;
    @(negedge clk); abort4 = 1'b0;
    chk("basic_pass", 32'(pass4), 32'd1);
    repeat (4) begin
      if (done4 === 1'b1) nd++;
      @(negedge clk);
    end
    chk("basic_done_once", 32'(nd), 32'd1);
    chk("basic_cutin_held", 32'(cutin4), 32'h8);
  endtask

  // Abort after at_c cycles of a run; captures completed by then is at_c/2.
  task automatic run_abort(input int at_c);
    logic [23:0] e;
    int unsigned nd;
    e = '0; nd = 0;
    for (int k = 0; k < at_c / 2; k++) e = misr_step(e, 24'h123456);
    @(negedge clk); seed4 = 20'h00001; cutout4 = 24'h123456; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    for (int c = 0; c < at_c; c++) @(negedge clk);
    abort4 = 1'b1;
    @(negedge clk); abort4 = 1'b0;
    chk("abort_busy", 32'(busy4), 32'd0);
    chk("abort_done", 32'(done4), 32'd0);
    chk("abort_pass", 32'(pass4), 32'd0);
    chk("abort_sig", 32'(sig4), 32'(e));
    repeat (6) begin
      @(negedge clk);
      if (done4 === 1'b1) nd++;
    end
    chk("abort_no_done", 32'(nd), 32'd0);
    chk("abort_sig_frozen", 32'(sig4), 32'(e));
  endtask

  typedef struct {
    logic [19:0] seed;
    logic [23:0] co;
    logic [23:0] gold;
    bit          ab;
    logic [19:0] exp_ci;
    logic [23:0] exp_sig;
    bit          exp_pass;
  } vec_t;

  vec_t tab [6];

  logic [19:0] pats [256];
  logic [19:0] s, p;
  logic [23:0] m_c, m_f, gold, exp_sig;
  bit          fault, exp_pass;
  int unsigned c, bad, zeros, nd;

  initial begin
    tab[0] = '{20'h00001, 24'h000001, 24'h000001, 1'b0, 20'h00001, 24'h000001, 1'b1};
    tab[1] = '{20'h00001, 24'h000001, 24'h000002, 1'b0, 20'h00001, 24'h000001, 1'b0};
    tab[2] = '{20'h00000, 24'h000000, 24'h000000, 1'b0, 20'h00001, 24'h000000, 1'b1};
    tab[3] = '{20'hFFFFF, 24'hFFFFFF, 24'hFFFFFF, 1'b1, 20'hFFFFF, 24'hFFFFFF, 1'b1};
    tab[4] = '{20'h81234, 24'hABCDEF, 24'hABCDEE, 1'b0, 20'h81234, 24'hABCDEF, 1'b0};
    tab[5] = '{20'h00000, 24'h800000, 24'h800000, 1'b1, 20'h00001, 24'h800000, 1'b1};

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy4), 32'd0);
    chk("rst_done", 32'(done4), 32'd0);
    chk("rst_pass", 32'(pass4), 32'd0);
    chk("rst_cutin", 32'(cutin4), 32'd0);
    chk("rst_sig", 32'(sig4), 32'd0);
    chk("rst_idx", 32'(idx4), 32'd0);
    rst_n = 1'b1;

    // Single-pattern vectors; signature of one capture from 0 equals cut_out.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seed1 = tab[i].seed; cutout1 = tab[i].co; golden1 = tab[i].gold;
      abort1 = tab[i].ab; start1 = 1'b1;
      @(negedge clk); start1 = 1'b0; abort1 = 1'b0;
      chk("v_busy", 32'(busy1), 32'd1);
      chk("v_cutin", 32'(cutin1), 32'(tab[i].exp_ci));
      chk("v_pass_clr", 32'(pass1), 32'd0);
      @(negedge clk);
      chk("v_done", 32'(done1), 32'd1);
      chk("v_busy_fall", 32'(busy1), 32'd0);
      chk("v_sig", 32'(sig1), 32'(tab[i].exp_sig));
      @(negedge clk);
      chk("v_pass", 32'(pass1), 32'(tab[i].exp_pass));
      chk("v_done_pulse", 32'(done1), 32'd0);
    end

    run_basic(1'b0);
    run_basic(1'b1);
    run_abort(5);
    run_abort(2);
    run_basic(1'b0);

    // Reset in the middle of a run.
    @(negedge clk); seed4 = 20'h00001; cutout4 = 24'h00F00F; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", 32'(busy4), 32'd0);
    chk("mrst_cutin", 32'(cutin4), 32'd0);
    chk("mrst_sig", 32'(sig4), 32'd0);
    chk("mrst_idx", 32'(idx4), 32'd0);
    chk("mrst_pass", 32'(pass4), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    nd = 0;
    repeat (10) begin
      @(negedge clk);
      if (done4 === 1'b1 || busy4 === 1'b1) nd++;
    end
    chk("mrst_quiet", 32'(nd), 32'd0);

    // Full-length runs with a behavioural CUT.
    for (int r = 0; r < 6; r++) begin
      s     = (r == 0) ? 20'h0 : 20'($urandom);
      fault = (r % 3 == 2);
      p     = (s == '0) ? 20'h1 : s;
      m_c   = '0;
      m_f   = '0;
      for (int i = 0; i < 256; i++) begin
        pats[i] = p;
        m_c = misr_step(m_c, cut_fn(p));
        m_f = misr_step(m_f, cut_fn(p) | 24'h000020);
        p = lfsr_step(p);
      end
      gold     = (r % 3 == 1) ? (m_c ^ 24'h000001) : m_c;
      exp_sig  = fault ? m_f : m_c;
      exp_pass = (exp_sig == gold);

      @(negedge clk); seed256 = s; golden256 = gold; stuck = fault; start256 = 1'b1;
      @(negedge clk); start256 = 1'b0;
      c = 0; bad = 0; zeros = 0;
      while (busy256 === 1'b1 && c < 600) begin
        if (c / 2 < 256) begin
          if (cutin256 !== pats[c / 2] || idx256 !== 16'(c / 2)) bad++;
        end else begin
          bad++;
        end
        if (cutin256 == '0) zeros++;
        c++;
        @(negedge clk);
      end
      chk("run_len", 32'(c), 32'd512);
      chk("run_patterns", 32'(bad), 32'd0);
      chk("run_lfsr_nonzero", 32'(zeros), 32'd0);
      chk("run_done", 32'(done256), 32'd1);
      chk("run_sig", 32'(sig256), 32'(exp_sig));
      @(negedge clk);
      chk("run_pass", 32'(pass256), 32'(exp_pass));
      golden256 = ~gold;
      @(negedge clk);
      chk("run_pass_held", 32'(pass256), 32'(exp_pass));
      chk("run_sig_held", 32'(sig256), 32'(exp_sig));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/stat_bist_ctrl.md
Name: stat_bist_ctrl

Overview:
Built-in self-test sequencer for the generated combinational benchmarks (20-input / 24-output class, e.g. Stat_128_*). It drives the circuit-under-test (CUT) inputs with LFSR pseudo-random patterns and waits a programmable settle time per pattern. It compacts the CUT outputs into a MISR signature and reports pass/fail against a golden signature. It sits between the test harness and one CUT instance and owns the CUT's inputs while a run is active.

Parameters:
IN_W, 20, CUT input width and LFSR width
OUT_W, 24, CUT output width and MISR width
PAT_CNT, 256, patterns applied per run (>=1)
SETTLE, 1, extra hold cycles per pattern before capture (>=0)
LFSR_TAPS, 20'h90000, feedback mask for the LFSR (default x^20+x^17+1)
MISR_TAPS, 24'hE10000, feedback mask for the MISR (default x^24+x^23+x^22+x^17+1)
CNT_W, 16, pattern counter width (must hold PAT_CNT)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse; begins a run when idle
abort  input  1  terminates a run in progress
seed  input  IN_W  LFSR seed, sampled on accepted start
golden  input  OUT_W  expected signature, compared at end of run
cut_in  output  IN_W  registered drive to CUT inputs
cut_out  input  OUT_W  CUT outputs (combinational from cut_in)
busy  output  1  high while a run is in progress
done  output  1  one-cycle pulse at run completion (not on abort)
pass  output  1  signature==golden, valid from done until next start
signature  output  OUT_W  MISR contents; held after run
pat_idx  output  CNT_W  index of the pattern currently applied

Behaviour:
- Reset (async, rst_n=0): state IDLE; cut_in=0, busy=0, done=0, pass=0, signature=0, pat_idx=0, hold counter=0.
- States: IDLE, HOLD, CAPTURE, FINISH.
- IDLE: on start=1 -> cut_in<=(seed==0 ? 1 : seed) (zero seed is forced to 1 to avoid lockup); signature<=0; pat_idx<=0; pass<=0; busy<=1; next state HOLD if SETTLE>0, else CAPTURE.
- HOLD: cut_in stable; counts SETTLE cycles, then goes to CAPTURE.
- CAPTURE (1 cycle): signature <= {sig[OUT_W-2:0], ^(sig & MISR_TAPS)} ^ cut_out.
  - If pat_idx==PAT_CNT-1 -> FINISH.
  - Else cut_in <= {cut_in[IN_W-2:0], ^(cut_in & LFSR_TAPS)}, pat_idx++, and next state is HOLD (or CAPTURE if SETTLE==0).
- Each pattern occupies exactly SETTLE+1 cycles. A run is busy for PAT_CNT*(SETTLE+1) cycles.
- FINISH (1 cycle): done=1; pass<=(signature==golden); busy<=0; then IDLE. busy falls in the same cycle done is high.
- signature, pass and cut_in hold their values in IDLE until the next accepted start.
- start while busy: ignored, with no effect on state.
- abort=1 in HOLD or CAPTURE: go to IDLE next cycle. busy=0, done stays 0, pass=0, and signature is frozen at its partial value (no capture that cycle). abort has priority over a coincident CAPTURE update. abort in IDLE or FINISH is ignored.
- start and abort both high in IDLE: the run starts (abort is ignored in IDLE).
- Reset asserted mid-run: immediate return to reset values. No done pulse.
- golden is sampled only in FINISH and may change freely otherwise.
- All outputs are registered. No combinational path from cut_out to any output.

Test Plan:
- Reset: rst_n low mid-run with busy=1 -> all outputs 0 immediately (async); no done pulse after release.
- Basic sequence: PAT_CNT=4, SETTLE=1, seed=0x00001, cut_out tied 0 -> cut_in goes 0x00001, 0x00002, 0x00004, 0x00008, each held 2 cycles; busy high 8 cycles; done pulses once; signature=0.
- Single-pattern MISR: PAT_CNT=1, SETTLE=0, cut_out=0x000001, golden=0x000001 -> busy 1 cycle, signature=0x000001, pass=1; repeat with golden=0x000002 -> pass=0.
- Zero seed: seed=0 -> first cut_in=0x00001; LFSR never reaches 0 over 256 patterns (checked against a reference model of the taps).
- Abort: assert abort during pattern 2 of a 4-pattern run -> busy low next cycle, done never pulses, signature is frozen, pass=0; a start afterwards runs cleanly from seed.
- Real CUT: connect a Stat_128-class CUT, PAT_CNT=256, SETTLE=1 -> signature matches the software golden model; one injected stuck-at on a CUT output -> pass=0.
